// File: rtl/mcu_pkg.sv
// mcu_pkg: state encoding, opcodes, ALU function codes and helpers shared by the MCU controller.
package mcu_pkg;
  typedef enum logic [3:0] {
    F0, F1, F2, F3, DEC, ALU0, ALU1, MEM0, MEM1, MEM2, JMP0, PSH0, POP0, HLT, POP1
  } state_t;
  localparam logic [3:0] OP_ALU   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_JMP   = 4'h3;
  localparam logic [3:0] OP_PUSH  = 4'h4;
  localparam logic [3:0] OP_POP   = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hf;
  localparam logic [2:0] FN_PASS  = 3'd0;
  localparam logic [2:0] FN_INC   = 3'd1;
  localparam logic [2:0] FN_DEC   = 3'd2;
  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_POP);
  endfunction
endpackage

// File: rtl/mcu_ctrl_decode.sv
// mcu_ctrl_decode: combinational strobes from state/latched opcode (status, mem_ready, reset gate a few outputs).
module mcu_ctrl_decode
  import mcu_pkg::*;
(
  input  logic       reset,
  input  logic [3:0] state,
  input  logic [3:0] op,
  input  logic       status,
  input  logic       mem_ready,
  output logic       ld_ir,
  output logic       ld_mar,
  output logic       ld_y,
  output logic       ld_sp,
  output logic       ld_pc,
  output logic       ld_reg,
  output logic       ld_mdr_mem,
  output logic       ld_mdr_z,
  output logic       t_pc,
  output logic       t_sp,
  output logic       t_reg,
  output logic       t_mdr_x,
  output logic       t_mdr_mem,
  output logic [2:0] controller_fn,
  output logic       carry_alu_func,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       halted
);
  always_comb begin
    ld_ir = 1'b0;
    ld_mar = 1'b0;
    ld_y = 1'b0;
    ld_sp = 1'b0;
    ld_pc = 1'b0;
    ld_reg = 1'b0;
    ld_mdr_mem = 1'b0;
    ld_mdr_z = 1'b0;
    t_pc = 1'b0;
    t_sp = 1'b0;
    t_reg = 1'b0;
    t_mdr_x = 1'b0;
    t_mdr_mem = 1'b0;
    controller_fn = FN_PASS;
    carry_alu_func = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    halted = 1'b0;
    // reset overrides the decode so strobes drop asynchronously with the state flop
    if (!reset) begin
      case (state_t'(state))
        F0: begin t_pc = 1'b1; ld_mar = 1'b1; end
        F1: begin mem_rd = 1'b1; ld_mdr_mem = mem_ready; end
        F2: begin t_pc = 1'b1; controller_fn = FN_INC; ld_pc = 1'b1; end
        F3: begin t_mdr_x = 1'b1; ld_ir = 1'b1; end
        ALU0: begin t_reg = 1'b1; ld_y = 1'b1; end
        ALU1: begin t_reg = 1'b1; carry_alu_func = 1'b1; ld_reg = 1'b1; end
        MEM0: begin t_reg = 1'b1; ld_mar = 1'b1; end
        MEM1: if (is_load(op)) begin
          mem_rd = 1'b1;
          ld_mdr_mem = mem_ready;
        end else begin
          t_reg = 1'b1;
          ld_mdr_z = 1'b1;
        end
        // POP bumps SP here and defers the register load to POP1 so the x bus has one driver
        MEM2: if (op == OP_POP) begin
          t_sp = 1'b1;
          controller_fn = FN_INC;
          ld_sp = 1'b1;
        end else if (is_load(op)) begin
          t_mdr_x = 1'b1;
          ld_reg = 1'b1;
        end else begin
          mem_wr = 1'b1;
          t_mdr_mem = 1'b1;
        end
        JMP0: begin t_reg = status; ld_pc = status; end
        PSH0: begin t_sp = 1'b1; controller_fn = FN_DEC; ld_sp = 1'b1; ld_mar = 1'b1; end
        POP0: begin t_sp = 1'b1; ld_mar = 1'b1; end
        POP1: begin t_mdr_x = 1'b1; ld_reg = 1'b1; end
        HLT: halted = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/mcu_controller.sv
// mcu_controller: fetch/decode/execute FSM; clk/reset in, opcode/status/mem_ready in, strobes, fn, state out.
module mcu_controller
  import mcu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       status,
  input  logic       mem_ready,
  output logic       ld_ir,
  output logic       ld_mar,
  output logic       ld_y,
  output logic       ld_sp,
  output logic       ld_pc,
  output logic       ld_reg,
  output logic       ld_mdr_mem,
  output logic       ld_mdr_z,
  output logic       t_pc,
  output logic       t_sp,
  output logic       t_reg,
  output logic       t_mdr_x,
  output logic       t_mdr_mem,
  output logic [2:0] controller_fn,
  output logic       carry_alu_func,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       halted,
  output logic [3:0] state
);
  state_t state_q, state_d;
  logic [3:0] op_q, op_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= F0;
      op_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
    end
  end
  always_comb begin
    op_d = (state_q == DEC) ? opcode : op_q;
    state_d = state_q;
    case (state_q)
      F0: state_d = F1;
      F1: state_d = mem_ready ? F2 : F1;
      F2: state_d = F3;
      F3: state_d = DEC;
      DEC: case (opcode)
        OP_ALU: state_d = ALU0;
        OP_LOAD, OP_STORE: state_d = MEM0;
        OP_JMP: state_d = JMP0;
        OP_PUSH: state_d = PSH0;
        OP_POP: state_d = POP0;
        OP_HALT: state_d = HLT;
        default: state_d = F0;
      endcase
      ALU0: state_d = ALU1;
      ALU1: state_d = F0;
      MEM0: state_d = MEM1;
      MEM1: state_d = (!is_load(op_q) || mem_ready) ? MEM2 : MEM1;
      MEM2: state_d = is_load(op_q) ? ((op_q == OP_POP) ? POP1 : F0) : (mem_ready ? F0 : MEM2);
      JMP0: state_d = F0;
      PSH0: state_d = MEM1;
      POP0: state_d = MEM1;
      POP1: state_d = F0;
      HLT: state_d = HLT;
      default: state_d = F0;
    endcase
  end
  assign state = state_q;
  mcu_ctrl_decode u_decode (
    .reset(reset), .state(state_q), .op(op_q), .status(status), .mem_ready(mem_ready),
    .ld_ir(ld_ir), .ld_mar(ld_mar), .ld_y(ld_y), .ld_sp(ld_sp), .ld_pc(ld_pc),
    .ld_reg(ld_reg), .ld_mdr_mem(ld_mdr_mem), .ld_mdr_z(ld_mdr_z),
    .t_pc(t_pc), .t_sp(t_sp), .t_reg(t_reg), .t_mdr_x(t_mdr_x), .t_mdr_mem(t_mdr_mem),
    .controller_fn(controller_fn), .carry_alu_func(carry_alu_func),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted)
  );
endmodule

// File: doc/mcu_controller.md
MCU_CONTROLLER -- requirements
Module: mcu_controller

Interface
REQ-001 Ports SHALL be: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-high reset.
REQ-002 opcode  in  4  IR[15:12] from datapath; status  in  1  selected condition flag; mem_ready  in  1  memory access complete.
REQ-003 ld_ir, ld_mar, ld_y, ld_sp, ld_pc, ld_reg, ld_mdr_mem, ld_mdr_z  out  1 each  register load strobes.
REQ-004 t_pc, t_sp, t_reg, t_mdr_x, t_mdr_mem  out  1 each  bus tri-state enables.
REQ-005 controller_fn  out  3  ALU function; carry_alu_func  out  1  1 selects IR[9:8] as the ALU function.
REQ-006 mem_rd, mem_wr  out  1 each  memory strobes; halted  out  1  HALT executed; state  out  4  debug state code.

Function
REQ-007 FSM states SHALL be: F0, F1, F2, F3, DEC, ALU0, ALU1, MEM0, MEM1, MEM2, JMP0, PSH0, POP0, HLT.
REQ-008 F0: t_pc, fn=PASS, ld_mar; next F1.
REQ-009 F1: mem_rd=1, ld_mdr_mem=mem_ready; stay in F1 while mem_ready=0; next F2 when mem_ready=1.
REQ-010 F2: t_pc, fn=INC, ld_pc; next F3.
REQ-011 F3: t_mdr_x, fn=PASS, ld_ir; next DEC.
REQ-012 DEC opcode decode: 0->ALU0, 1 (LOAD)->MEM0, 2 (STORE)->MEM0, 3 (JMP)->JMP0, 4 (PUSH)->PSH0, 5 (POP)->POP0, F (HALT)->HLT, others->F0 (NOP).
REQ-013 ALU0: t_reg, ld_y; next ALU1. ALU1: t_reg, carry_alu_func=1, ld_reg; next F0.
REQ-014 MEM0: t_reg, fn=PASS, ld_mar; next MEM1.
REQ-015 MEM1 for LOAD: mem_rd=1, ld_mdr_mem=mem_ready; waits on mem_ready.
REQ-016 MEM1 for STORE: t_reg, fn=PASS, ld_mdr_z; next MEM2.
REQ-017 MEM2 for LOAD: t_mdr_x, fn=PASS, ld_reg; next F0.
REQ-018 MEM2 for STORE: mem_wr=1 and t_mdr_mem=1; held until mem_ready=1; next F0.
REQ-019 JMP0: if status=1, t_reg, fn=PASS, ld_pc; if status=0, no strobes; next F0 in either case.
REQ-020 PSH0: t_sp, fn=DEC, ld_sp, ld_mar; next MEM1 with STORE behaviour.
REQ-021 POP0: t_sp, fn=PASS, ld_mar; next MEM1 with LOAD behaviour; SP is incremented in MEM2 via t_sp, fn=INC, ld_sp.
REQ-021 has one exception: the POP register load SHALL occur in an extra cycle after MEM2, so the x bus has one driver per cycle.
REQ-022 HLT: halted=1; no strobes; remain in HLT until reset.
REQ-023 All outputs SHALL be Moore, decoded from state plus the registered opcode copy, except ld_mdr_mem, which is gated by mem_ready.
REQ-024 At most one of t_pc, t_sp, t_reg, t_mdr_x SHALL be 1 in any cycle; mem_rd and mem_wr SHALL never both be 1.
REQ-025 opcode SHALL be sampled into an internal register in DEC; later opcode changes SHALL not affect the current instruction.
REQ-026 mem_ready asserted outside a memory-wait state SHALL be ignored.

Reset
REQ-027 reset=1 SHALL force state to F0, all strobes to 0, controller_fn=PASS, halted=0, asynchronously and within the same cycle.
REQ-028 Reset during a memory wait SHALL drop mem_rd/mem_wr immediately; fetch SHALL restart at F0 on the first clk edge after deassertion.

Structure
REQ-029 A shared package mcu_pkg SHALL hold the state encoding, the opcode constants, and the ALU function codes (PASS=0, INC=1, DEC=2; 3-7 are ALU-defined).
REQ-030 One sub-module, mcu_ctrl_decode, SHALL hold the combinational decode from state and opcode to strobes; mcu_controller SHALL hold the state register and next-state logic.

Verification
REQ-031 Reset then NOP (opcode 7), mem_ready=1: sequence F0,F1,F2,F3,DEC,F0, with ld_pc pulsed once in F2 using fn=1.
REQ-032 Fetch with mem_ready low for 3 cycles: mem_rd held 4 cycles, ld_mdr_mem high only in the last cycle, F2 one cycle later.
REQ-033 JMP with status=0, then JMP with status=1: ld_pc in JMP0 is 0 for the first and 1 for the second.
REQ-034 PUSH: ld_sp with fn=2 in PSH0; mem_wr stays high in MEM2 until mem_ready=1; no bus-driver conflict is flagged.
REQ-035 HALT, then 10 cycles: halted=1 and state stays HLT; reset asserted mid-cycle: halted=0 and state=F0 immediately.
REQ-036 A continuous assertion SHALL check REQ-024 in every scenario.
